iris_layer_driver: RTL and testbench
====================================

Name: iris_layer_driver

Overview:
Initiator side of the neuron Run/X/Y interface in the Iris network. Accepts one 4-feature sample via valid/ready and drives the shared X inputs, Run and En of N_OUT parallel layer neurons. Waits out the fixed neuron latency, captures every neuron Y, and presents the result vector downstream via valid/ready. Sits between an input buffer (or the previous layer driver) and the next layer or classifier.

Parameters:
DATA_WIDTH, 8, signed fixed-point word width (matches the neurons)
N_OUT, 3, number of neurons driven in parallel
WAIT_CYCLES, 7, clock edges from the neuron's Run-sampling edge to the capture-minus-one edge; must be >= 7

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
s_valid  in  1  input sample valid
s_ready  out  1  driver can accept a sample
s_x  in  4*DATA_WIDTH  packed signed features; X1 = bits [DATA_WIDTH-1:0], X4 = top slice
n_en  out  1  neuron En
n_run  out  1  neuron Run, one-cycle pulse
n_x1..n_x4  out  DATA_WIDTH each  registered features broadcast to all neurons
n_y  in  N_OUT*DATA_WIDTH  packed neuron outputs; neuron i = slice i
m_valid  out  1  result vector valid
m_ready  in  1  downstream accepts result
m_y  out  N_OUT*DATA_WIDTH  captured neuron outputs, same packing as n_y
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; n_x1..n_x4=0, m_y=0, m_valid=0, counter=0. s_ready=0 while rst is high.
- s_ready = (state==IDLE) && !rst. n_run = (state==RUN). n_en = (state==RUN || state==WAIT). busy = (state!=IDLE).
- States:
  - IDLE: on s_valid&&s_ready at edge k, latch s_x into n_x1..n_x4 -> RUN.
  - RUN: single cycle. The neurons sample Run=1 at edge k+1 -> WAIT; counter <= WAIT_CYCLES-1.
  - WAIT: counter decrements each edge. At the edge where counter==0, capture n_y into m_y, m_valid<=1 -> OUT.
  - OUT: m_y and m_valid held stable. On m_valid&&m_ready, m_valid<=0 -> IDLE.
- Timing (default WAIT_CYCLES): capture at edge k+8. The neuron Y is updated at k+7, so sampling is safe. m_valid is high from after k+8. Minimum turnaround is 10 cycles per sample.
- n_x1..n_x4 stay constant from accept until the next accept. They must stay stable through the neuron's load edge (k+2).
- s_valid while busy: ignored, no latch. The upstream must hold its data (standard valid/ready).
- m_ready while not OUT: ignored.
- No bypass. A new sample is accepted only in IDLE, one cycle after the OUT handshake.
- Reset in any state aborts the operation. Any partial result is discarded and m_valid is never raised for it.
- No arithmetic on data. m_y is a bit-exact copy of n_y.

Optional Feature:
IRIS_ARGMAX_EN
- Defined: adds port m_class, out, $clog2(N_OUT) bits. It holds the index of the maximum signed slice of n_y, ties resolved to the lowest index. It is registered at the capture edge together with m_y, resets to 0, and is held with m_y through OUT.
- Undefined: the port and the comparison logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package iris_net_pkg holds:
  - DATA_WIDTH default and N_FEATURES=4
  - NEURON_LATENCY=7
  - the driver state enum typedef (IDLE, RUN, WAIT, OUT)
- Sub-module iris_argmax: combinational signed max-index over N_OUT packed words. Instantiated only under IRIS_ARGMAX_EN.

Test Plan:
- Bench neurons are behavioural models with 7-cycle latency, or real layer neurons.
- Basic: s_x=(X1..X4)=(16,32,-16,8) accepted at edge k -> n_run high exactly one cycle, after k; n_x1..n_x4 hold those values; m_valid rises after edge k+8 with m_y = neuron outputs, e.g. slices (5,12,0).
- Backpressure: hold m_ready=0 for 20 cycles after m_valid -> m_y/m_valid stable, s_ready=0 throughout; m_ready=1 -> m_valid falls at the next edge, s_ready=1 one cycle later.
- Busy input: s_valid=1 continuously with changing s_x -> exactly one sample accepted per round trip; n_x only changes at accept edges.
- Reset mid-WAIT: assert rst at counter==3 -> immediate IDLE, m_valid stays 0, n_x=0; the next sample then completes normally with latency 8.
- Back-to-back: 4 samples with m_ready=1 -> 4 results in order, each 10 cycles apart.
- IRIS_ARGMAX_EN: n_y slices (7,7,-3) -> m_class=0; slices (-8,-2,-5) -> m_class=1.

Source files
------------

// File: rtl/iris_net_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iris_net_pkg
// Description : Shared definitions for the Iris network layer logic:
//               default word width, feature count, neuron latency and the
//               layer driver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package iris_net_pkg;

  localparam int DATA_WIDTH_DEF = 8;  // signed fixed-point word width
  localparam int N_FEATURES     = 4;  // features per sample (X1..X4)
  localparam int NEURON_LATENCY = 7;  // Run-sample edge to Y-update edge

  // Layer driver sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a sample
    ST_RUN  = 2'd1,  // one-cycle Run pulse to the neurons
    ST_WAIT = 2'd2,  // waiting out the neuron latency
    ST_OUT  = 2'd3   // result vector presented downstream
  } drv_state_t;

endpackage
`default_nettype wire

// File: rtl/iris_argmax.sv
`default_nettype none
// ============================================================================
// Module      : iris_argmax
// Description : Combinational signed max-index over N_OUT packed words.
//               Ties resolve to the lowest index.
// Ports       : y   in  N_OUT*DATA_WIDTH  packed signed words, word i = slice i
//               idx out $clog2(N_OUT)     index of the largest word
// Revision    : 1.0 - initial release
// ============================================================================
module iris_argmax #(
  parameter int DATA_WIDTH = 8,
  parameter int N_OUT      = 3   // must be >= 2
) (
  input  logic [N_OUT*DATA_WIDTH-1:0] y,
  output logic [$clog2(N_OUT)-1:0]    idx
);

  localparam int IDX_W = $clog2(N_OUT);

  logic signed [DATA_WIDTH-1:0] best;

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
    best = y[DATA_WIDTH-1:0];
    idx  = '0;
    for (int i = 1; i < N_OUT; i++) begin
      if ($signed(y[i*DATA_WIDTH +: DATA_WIDTH]) > best) begin
        best = y[i*DATA_WIDTH +: DATA_WIDTH];
        idx  = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iris_layer_driver.sv
`default_nettype none
// ============================================================================
// Module      : iris_layer_driver
// Description : Initiator side of the neuron Run/X/Y interface. Accepts one
//               4-feature sample (valid/ready), broadcasts registered X to
//               N_OUT neurons, pulses Run, waits out the neuron latency,
//               captures all Y and presents them downstream (valid/ready).
// Ports       : clk, rst (async, active-high)
//               s_valid/s_ready/s_x       upstream sample
//               n_en, n_run, n_x1..n_x4   neuron control and features
//               n_y                       neuron outputs
//               m_valid/m_ready/m_y       downstream result
//               m_class                   argmax of n_y (IRIS_ARGMAX_EN only)
//               busy                      state != IDLE
// Config      : `define IRIS_ARGMAX_EN adds m_class and the argmax logic.
// Revision    : 1.0 - initial release
// ============================================================================
module iris_layer_driver
  import iris_net_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int N_OUT       = 3,
  parameter int WAIT_CYCLES = NEURON_LATENCY  // must be >= NEURON_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [N_FEATURES*DATA_WIDTH-1:0] s_x,
  output logic                             n_en,
  output logic                             n_run,
  output logic [DATA_WIDTH-1:0]            n_x1,
  output logic [DATA_WIDTH-1:0]            n_x2,
  output logic [DATA_WIDTH-1:0]            n_x3,
  output logic [DATA_WIDTH-1:0]            n_x4,
  input  logic [N_OUT*DATA_WIDTH-1:0]      n_y,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [N_OUT*DATA_WIDTH-1:0]      m_y,
`ifdef IRIS_ARGMAX_EN
  output logic [$clog2(N_OUT)-1:0]         m_class,
`endif
  output logic                             busy
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  drv_state_t       state;
  drv_state_t       state_nxt;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             capture;

  assign accept  = s_valid && s_ready;
  assign capture = (state == ST_WAIT) && (count == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)        state_nxt = ST_RUN;
      ST_RUN:                     state_nxt = ST_WAIT;
      ST_WAIT: if (count == '0)   state_nxt = ST_OUT;
      ST_OUT:  if (m_ready)       state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. s_ready is gated by rst so nothing is accepted while the
  // block is held in reset.
  // --------------------------------------------------------------------------
  always_comb begin
    s_ready = (state == ST_IDLE) && !rst;
    n_run   = (state == ST_RUN);
    n_en    = (state == ST_RUN) || (state == ST_WAIT);
    busy    = (state != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Feature registers: only written on accept, so X stays stable through
  // the neuron load edge and until the next sample.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_x1 <= '0;
      n_x2 <= '0;
      n_x3 <= '0;
      n_x4 <= '0;
    end else if (accept) begin
      n_x1 <= s_x[0*DATA_WIDTH +: DATA_WIDTH];
      n_x2 <= s_x[1*DATA_WIDTH +: DATA_WIDTH];
      n_x3 <= s_x[2*DATA_WIDTH +: DATA_WIDTH];
      n_x4 <= s_x[3*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // --------------------------------------------------------------------------
  // Latency counter: loaded on the Run-sampling edge, reaches zero on the
  // edge before capture so capture lands WAIT_CYCLES+1 edges after Run.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state == ST_RUN) begin
      count <= CNT_W'(WAIT_CYCLES - 1);
    end else if ((state == ST_WAIT) && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Result capture and downstream handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y     <= '0;
      m_valid <= 1'b0;
    end else if (capture) begin
      m_y     <= n_y;
      m_valid <= 1'b1;
    end else if ((state == ST_OUT) && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef IRIS_ARGMAX_EN
  logic [$clog2(N_OUT)-1:0] max_idx;

  iris_argmax #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_OUT      (N_OUT)
  ) u_argmax (
    .y   (n_y),
    .idx (max_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_class <= '0;
    end else if (capture) begin
      m_class <= max_idx;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iris_layer_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_iris_layer_driver
// Description : Self-checking bench for iris_layer_driver. Behavioural
//               neurons (7-cycle latency) answer from a queue of programmed
//               results; table vectors, hand-written corner sequences and a
//               randomized phase checked against a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iris_layer_driver;

  localparam int DW  = 8;
  localparam int NO  = 3;
  localparam int WC  = 7;
  localparam int LAT = 8;   // accept edge to capture edge

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_x;
  logic          n_en;
  logic          n_run;
  logic [DW-1:0] n_x1, n_x2, n_x3, n_x4;
  logic [23:0]   n_y = '0;
  logic          m_valid;
  logic          m_ready;
  logic [23:0]   m_y;
  logic          busy;
`ifdef IRIS_ARGMAX_EN
  logic [1:0]    m_class;
`endif

  iris_layer_driver #(
    .DATA_WIDTH  (DW),
    .N_OUT       (NO),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x     (s_x),
    .n_en    (n_en),
    .n_run   (n_run),
    .n_x1    (n_x1),
    .n_x2    (n_x2),
    .n_x3    (n_x3),
    .n_x4    (n_x4),
    .n_y     (n_y),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_y     (m_y),
`ifdef IRIS_ARGMAX_EN
    .m_class (m_class),
`endif
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural neurons: sample Run, update Y 6 edges later (7 edges after
  // the Run-sampling edge counting that edge itself as latency origin k+1).
  logic [23:0] nrn_q[$];
  logic [23:0] nrn_pend = '0;
  int          nrn_cnt  = 0;

  always @(posedge clk) begin
    if (n_run) begin
      nrn_pend <= (nrn_q.size() > 0) ? nrn_q.pop_front() : 24'hA5A5A5;
      nrn_cnt  <= 6;
    end else if (nrn_cnt > 0) begin
      nrn_cnt <= nrn_cnt - 1;
      if (nrn_cnt == 1) n_y <= nrn_pend;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] last_x = '0;
  logic [23:0] last_y = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nx_all();
    return {n_x4, n_x3, n_x2, n_x1};
  endfunction

`ifdef IRIS_ARGMAX_EN
  function automatic logic [1:0] ref_cls(input logic [23:0] y);
    int best = 0;
    for (int i = 1; i < 3; i++)
      if ($signed(y[i*8 +: 8]) > $signed(y[best*8 +: 8])) best = i;
    return 2'(best);
  endfunction
`endif

  typedef struct {
    logic [31:0] x;     // {X4,X3,X2,X1}
    logic [23:0] y;     // neuron outputs {Y2,Y1,Y0}
    int          hold;  // cycles of m_ready=0 after m_valid
  } vec_t;

  // One full transaction with upstream spamming s_valid while busy.
  task automatic run_one(input vec_t v, input string tag);
    int w;
    int cyc;
    int runs;
    nrn_q.push_back(v.y);
    w = 0;
    while (!s_ready && w < 20) begin @(negedge clk); w++; end
    chk({tag, "_ready_in"}, 64'(s_ready), 64'd1);
    s_valid = 1'b1; s_x = v.x; m_ready = 1'b0;
    @(negedge clk);                      // after accept edge k
    chk({tag, "_run"},  64'(n_run),  64'd1);
    chk({tag, "_nx"},   64'(nx_all()), 64'(v.x));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    last_x = v.x;
    cyc = 0; runs = 0;
    while (!m_valid && cyc < 30) begin
      s_valid = 1'b1; s_x = $urandom;   // must be ignored while busy
      @(negedge clk);
      cyc++;
      if (n_run) runs++;
      chk({tag, "_nx_hold"}, 64'(nx_all()), 64'(v.x));
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
    chk({tag, "_run_once"}, 64'(runs), 64'd0);
    chk({tag, "_m_y"}, 64'(m_y), 64'(v.y));
`ifdef IRIS_ARGMAX_EN
    chk({tag, "_class"}, 64'(m_class), 64'(ref_cls(v.y)));
`endif
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(m_valid), 64'd1);
      chk({tag, "_hold_y"}, 64'(m_y), 64'(v.y));
      chk({tag, "_hold_sready"}, 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);                      // after handshake edge
    chk({tag, "_valid_fall"}, 64'(m_valid), 64'd0);
    chk({tag, "_sready_back"}, 64'(s_ready), 64'd1);
    chk({tag, "_nx_keep"}, 64'(nx_all()), 64'(v.x));
    m_ready = 1'b0;
    last_y = v.y;
  endtask

  // Cycle-level reference: idle / computing (t edges since accept) / output.
  task automatic run_model(input int ncycles, input bit rnd, output int dut_results);
    bit          idle = 1'b1;
    bit          out  = 1'b0;
    int          t    = 0;
    logic [31:0] mx   = last_x;
    logic [23:0] my   = last_y;
    logic [23:0] pend = '0;
    logic [23:0] ny;
    bit          sv, mr;
    logic [31:0] x;
    dut_results = 0;
    for (int c = 0; c < ncycles; c++) begin
      sv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mr = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      x  = $urandom;
      s_valid = sv; s_x = x; m_ready = mr;
      chk("mdl_s_ready", 64'(s_ready), 64'(idle));
      if (m_valid && mr) dut_results++;
      if (idle) begin
        if (sv) begin
          idle = 1'b0; t = 0; mx = x;
          ny = 24'($urandom);
          nrn_q.push_back(ny);
          pend = ny;
        end
      end else if (!out) begin
        t++;
        if (t == LAT) begin out = 1'b1; my = pend; end
      end else if (mr) begin
        out = 1'b0; idle = 1'b1;
      end
      @(negedge clk);
      chk("mdl_m_valid", 64'(m_valid), 64'(out));
      chk("mdl_busy",    64'(busy),    64'(!idle));
      chk("mdl_n_run",   64'(n_run),   64'(!idle && !out && t == 0));
      chk("mdl_n_en",    64'(n_en),    64'(!idle && !out));
      chk("mdl_n_x",     64'(nx_all()), 64'(mx));
      if (out) begin
        chk("mdl_m_y", 64'(m_y), 64'(my));
`ifdef IRIS_ARGMAX_EN
        chk("mdl_class", 64'(m_class), 64'(ref_cls(my)));
`endif
      end
    end
    s_valid = 1'b0; m_ready = 1'b0;
    last_x = mx; last_y = my;
  endtask

  vec_t vecs[6];
  int   nres;

  initial begin
    vecs[0] = '{x: 32'h08F02010, y: 24'h000C05, hold: 0};   // (16,32,-16,8) -> (5,12,0)
    vecs[1] = '{x: 32'h7F8000FF, y: 24'hFF807F, hold: 20};  // backpressure, extremes
    vecs[2] = '{x: 32'h01020304, y: 24'hFD0707, hold: 3};   // (7,7,-3) tie
    vecs[3] = '{x: 32'hFFFFFFFF, y: 24'hFBFEF8, hold: 1};   // (-8,-2,-5)
    vecs[4] = '{x: 32'h00000000, y: 24'h000000, hold: 0};
    vecs[5] = '{x: 32'h80808080, y: 24'h7F8080, hold: 5};   // (-128,-128,127)

    rst = 1'b1; s_valid = 1'b0; s_x = '0; m_ready = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_y",     64'(m_y),     64'd0);
    chk("rst_n_x",     64'(nx_all()), 64'd0);
    chk("rst_run_en",  64'({n_run, n_en}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 64'(s_ready), 64'd1);
    m_ready = 1'b1;                      // m_ready outside OUT is ignored
    @(negedge clk);
    chk("idle_m_ready_ignored", 64'({m_valid, busy}), 64'd0);
    m_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Reset while counter == 3 (four edges after accept edge k)
    nrn_q.push_back(24'h123456);
    s_valid = 1'b1; s_x = 32'h11223344;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy",    64'(busy),    64'd0);
    chk("abort_s_ready", 64'(s_ready), 64'd0);
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    chk("abort_n_x",     64'(nx_all()), 64'd0);
    chk("abort_m_y",     64'(m_y),     64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(m_valid), 64'd0);
    end
    last_x = '0;
    run_one('{x: 32'hC0DEBEEF, y: 24'h5AA5C3, hold: 2}, "post_abort");

    // Back-to-back: 4 samples, m_ready held high
    run_model(40, 1'b0, nres);
    chk("b2b_results", 64'(nres), 64'd4);

    // Randomized valid/ready traffic
    run_model(400, 1'b1, nres);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
